wb_mem_responder: RTL and testbench

- Wishbone B4 responder: a single-port word memory behind a Wishbone slave port.
- It is the target end for the DSP block's Wishbone master port, so the master's file/result traffic runs against it in simulation and on FPGA builds.
- Supports classic cycles and registered-feedback incrementing bursts (linear, wrap-4/8/16), byte-lane writes, programmable wait states, and error/retry responses.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_burst_addr_gen.sv | 38 +++
 rtl/wb_mem_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_wb_mem_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared Wishbone B4 encodings (cycle type, burst type) and the
//               responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Cycle type identifiers (wb_cti)
    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [2:0] c_cti_incr    = 3'b010;
    localparam logic [2:0] c_cti_eob     = 3'b111;

    // Burst type extensions (wb_bte)
    localparam logic [1:0] c_bte_linear  = 2'b00;
    localparam logic [1:0] c_bte_wrap4   = 2'b01;
    localparam logic [1:0] c_bte_wrap8   = 2'b10;
    localparam logic [1:0] c_bte_wrap16  = 2'b11;

    // Responder state encoding
    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait     = 2'd1;
    localparam logic [1:0] c_st_beat     = 2'd2;
    localparam logic [1:0] c_st_err      = 3'd3;

endpackage
`default_nettype wire

// File: rtl/wb_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_burst_addr_gen
// Description : Next-beat byte address for Wishbone incrementing bursts.
//               Linear bursts add 4; wrap bursts only step the low bits that
//               index the wrap block and hold the upper bits.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_addr,
    input  logic [1:0]    i_bte,
    output logic [AW-1:0] o_next_addr
);

    logic [AW-1:0] w_inc;
    logic [AW-1:0] w_mask;

    assign w_inc = i_addr + AW'(4);

    // Select which low address bits may change for the current burst type
    always_comb begin
        w_mask = '1;
        case (i_bte)
            c_bte_wrap4:  w_mask = AW'(32'h0000_000F);
            c_bte_wrap8:  w_mask = AW'(32'h0000_001F);
            c_bte_wrap16: w_mask = AW'(32'h0000_003F);
            default:      w_mask = '1;
        endcase
    end

    assign o_next_addr = (i_addr & ~w_mask) | (w_inc & w_mask);

endmodule
`default_nettype wire

// File: rtl/wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_responder
// Description : Wishbone B4 slave backed by a single-port word memory.
//               Classic and registered-feedback incrementing bursts, byte
//               lanes, programmable wait states, err/rty terminations.
//               Read data is fetched on entry to a beat; write data is taken
//               on the edge that completes the acknowledged beat.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_responder
    import wb_pkg::*;
#(
    parameter int              DW           = 32,
    parameter int              AW           = 32,
    parameter logic [AW-1:0]   BASE_ADDRESS = '0,
    parameter int              DEPTH_LOG2   = 8,
    parameter int              WAIT_STATES  = 0
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    localparam int          c_depth = 2 ** DEPTH_LOG2;
    localparam logic [AW:0] c_span  = (AW+1)'(c_depth) << 2;
    localparam logic [3:0]  c_ws    = 4'(WAIT_STATES);
    localparam logic [3:0]  c_ws_m1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [DW-1:0] r_mem [0:c_depth-1];

    logic [1:0]    r_state, w_state_nxt;
    logic [AW-1:0] r_adr, w_adr_nxt;
    logic          r_bad, w_bad_nxt;
    logic          r_burst, w_burst_nxt;
    logic [3:0]    r_wcnt, w_wcnt_nxt;
    logic          r_ack, r_err, r_rty;
    logic          w_ack_nxt, w_err_nxt, w_rty_nxt;
    logic [DW-1:0] r_dat;
    logic          w_rd_en, w_wr_en;
    logic [AW-1:0] w_rd_adr;
    logic [AW-1:0] w_next_adr;
    logic          w_req, w_cti_rsvd;

    // Word-aligned and inside the memory window
    function automatic logic f_in_range(input logic [AW-1:0] a);
        logic [AW:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDRESS};
        return (a >= BASE_ADDRESS) && (off < c_span) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] f_idx(input logic [AW-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDRESS) >> 2);
    endfunction

    assign w_req      = wb_cyc_i & wb_stb_i;
    assign w_cti_rsvd = !((wb_cti_i == c_cti_classic) || (wb_cti_i == c_cti_incr) ||
                          (wb_cti_i == c_cti_eob));

    wb_burst_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .i_addr      (r_adr),
        .i_bte       (wb_bte_i),
        .o_next_addr (w_next_adr)
    );

    // State register plus registered terminations and read data
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= c_st_idle;
            r_adr   <= '0;
            r_bad   <= 1'b0;
            r_burst <= 1'b0;
            r_wcnt  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_adr   <= w_adr_nxt;
            r_bad   <= w_bad_nxt;
            r_burst <= w_burst_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_rty   <= w_rty_nxt;
            if (w_rd_en) begin
                r_dat <= r_mem[f_idx(w_rd_adr)];
            end
        end
    end

    // Next-state, termination and memory-strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_adr_nxt   = r_adr;
        w_bad_nxt   = r_bad;
        w_burst_nxt = r_burst;
        w_wcnt_nxt  = r_wcnt;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_rty_nxt   = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_adr    = r_adr;
        w_wr_en     = 1'b0;
        case (r_state)
            c_st_idle: begin
                // r_rty guards against re-answering the request that is
                // still on the bus while rty is visible
                if (w_req && !r_rty) begin
                    if (w_cti_rsvd) begin
                        w_rty_nxt = 1'b1;
                    end else begin
                        w_adr_nxt   = wb_adr_i;
                        w_bad_nxt   = !f_in_range(wb_adr_i);
                        w_burst_nxt = 1'b0;
                        if (WAIT_STATES == 0) begin
                            if (!f_in_range(wb_adr_i)) begin
                                w_state_nxt = c_st_err;
                                w_err_nxt   = 1'b1;
                            end else begin
                                w_state_nxt = c_st_beat;
                                w_ack_nxt   = 1'b1;
                                w_rd_en     = !wb_we_i;
                                w_rd_adr    = wb_adr_i;
                            end
                        end else begin
                            w_state_nxt = c_st_wait;
                            w_wcnt_nxt  = c_ws_m1;
                        end
                    end
                end
            end
            c_st_wait: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = c_st_idle;
                end else if (!wb_stb_i) begin
                    // A stall inside a burst keeps the counter address and
                    // restarts the full wait once the master resumes
                    if (r_burst) begin
                        w_wcnt_nxt = c_ws;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end else if (r_wcnt != 4'd0) begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end else if (r_bad) begin
                    w_state_nxt = c_st_err;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = c_st_beat;
                    w_ack_nxt   = 1'b1;
                    w_rd_en     = !wb_we_i;
                end
            end
            c_st_beat: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = c_st_idle;
                end else if (!wb_stb_i) begin
                    // Beat not taken by the master: hold the address
                    w_state_nxt = r_burst ? c_st_wait : c_st_idle;
                    w_wcnt_nxt  = c_ws;
                end else begin
                    w_wr_en = wb_we_i;
                    if (wb_cti_i == c_cti_incr) begin
                        w_adr_nxt   = w_next_adr;
                        w_bad_nxt   = !f_in_range(w_next_adr);
                        w_burst_nxt = 1'b1;
                        if (WAIT_STATES == 0) begin
                            if (!f_in_range(w_next_adr)) begin
                                w_state_nxt = c_st_err;
                                w_err_nxt   = 1'b1;
                            end else begin
                                w_ack_nxt   = 1'b1;
                                w_rd_en     = !wb_we_i;
                                w_rd_adr    = w_next_adr;
                            end
                        end else begin
                            w_state_nxt = c_st_wait;
                            w_wcnt_nxt  = c_ws_m1;
                        end
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Byte-lane write on the edge that completes an acknowledged write beat
    always_ff @(posedge wb_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    r_mem[f_idx(r_adr)][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_rty_o = r_rty;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_mem_responder
// Description : Self-checking bench for wb_mem_responder. Two instances:
//               u_dut0 with no wait states, u_dut1 with two. Expected
//               terminations, latencies and read data are queued before each
//               transfer and popped as the DUT terminates beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_mem_responder;

    localparam logic [2:0] c_t_ack = 3'b100;
    localparam logic [2:0] c_t_err = 3'b010;
    localparam logic [2:0] c_t_rty = 3'b001;

    typedef struct {
        string       tag;
        logic [2:0]  term;
        bit          chk_dat;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    int          dsel;
    logic        cyc0, stb0, cyc1, stb1;
    logic [31:0] rdat0, rdat1, rdat;
    logic        ack0, err0, rty0, ack1, err1, rty1;
    logic [2:0]  term;

    exp_t        sb[$];
    logic [31:0] wq[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign cyc0 = cyc & (dsel == 0);
    assign stb0 = stb & (dsel == 0);
    assign cyc1 = cyc & (dsel == 1);
    assign stb1 = stb & (dsel == 1);
    assign rdat = (dsel == 0) ? rdat0 : rdat1;
    assign term = (dsel == 0) ? {ack0, err0, rty0} : {ack1, err1, rty1};

    wb_mem_responder #(
        .DW(32), .AW(32), .BASE_ADDRESS(32'h0), .DEPTH_LOG2(8), .WAIT_STATES(0)
    ) u_dut0 (
        .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb0),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(rdat0), .wb_ack_o(ack0),
        .wb_err_o(err0), .wb_rty_o(rty0)
    );

    wb_mem_responder #(
        .DW(32), .AW(32), .BASE_ADDRESS(32'h0), .DEPTH_LOG2(8), .WAIT_STATES(2)
    ) u_dut1 (
        .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb1),
        .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(rdat1), .wb_ack_o(ack1),
        .wb_err_o(err1), .wb_rty_o(rty1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] t, input bit c,
                            input logic [31:0] d, input int l);
        exp_t e;
        e.tag = tag; e.term = t; e.chk_dat = c; e.dat = d; e.lat = l;
        sb.push_back(e);
    endtask

    // Reference next-beat address: modular arithmetic inside the wrap block
    function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] b);
        logic [31:0] span;
        if (b == 2'b00) return a + 32'd4;
        span = 32'd16 << (b - 2'd1);
        return (a / span) * span + ((a % span) + 32'd4) % span;
    endfunction

    task automatic wait_term(input int lat_in, output int lat_out, output bit tmo);
        int l;
        l = lat_in;
        tmo = 1'b0;
        while (term == 3'b000) begin
            if (l >= 40) begin
                tmo = 1'b1;
                break;
            end
            @(posedge clk); #1;
            l++;
        end
        lat_out = l;
    endtask

    task automatic score_beat(input int lat, input bit tmo);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_underflow: got term %b with nothing expected", term);
            return;
        end
        e = sb.pop_front();
        if (tmo) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: got no termination expected %b", e.tag, e.term);
            return;
        end
        check_val({e.tag, "_term"}, 32'(term), 32'(e.term));
        check_val({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
        if (e.chk_dat && e.term == c_t_ack) check_val({e.tag, "_dat"}, rdat, e.dat);
    endtask

    // One Wishbone transfer of n beats; optional stb stall after beat stall_after
    task automatic run_xfer(input int d, input logic [31:0] a0, input int n, input logic w,
                            input logic [3:0] s, input logic [1:0] b, input logic [2:0] cmode,
                            input int stall_after, input int stall_len, input string tag);
        logic [31:0] a;
        int          lat;
        bit          tmo;
        bit          any;
        a    = a0;
        lat  = 0;
        dsel = d;
        for (int k = 0; k < n; k++) begin
            adr  = a;
            wdat = (w && wq.size() > 0) ? wq.pop_front() : 32'h0;
            sel  = s;
            we   = w;
            bte  = b;
            cti  = (n == 1) ? cmode : ((k == n - 1) ? 3'b111 : cmode);
            cyc  = 1'b1;
            stb  = 1'b1;
            wait_term(lat, lat, tmo);
            score_beat(lat, tmo);
            if (tmo || term != c_t_ack || k == n - 1) break;
            @(posedge clk); #1;
            lat = 1;
            a = next_adr(a, b);
            if (k == stall_after) begin
                stb = 1'b0;
                adr = a;
                any = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    if (term != 3'b000) any = 1'b1;
                    @(posedge clk); #1;
                end
                check_val({tag, "_stall_quiet"}, 32'(any), 32'd0);
                lat = 0;
            end
        end
        @(posedge clk); #1;
        check_val({tag, "_term_drop"}, 32'(term), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        wq.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        adr = '0; wdat = '0; sel = 4'hF; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        cti = 3'b000; bte = 2'b00; dsel = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_term0", {29'd0, ack0, err0, rty0}, 32'd0);
        check_val("rst_dat0", rdat0, 32'd0);
        check_val("rst_term1", {29'd0, ack1, err1, rty1}, 32'd0);
        check_val("rst_dat1", rdat1, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Classic write then read
        wq.push_back(32'hDEAD_BEEF);
        push_exp("t1_wr", c_t_ack, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h10, 1, 1'b1, 4'hF, 2'b00, 3'b000, -1, 0, "t1_wr");
        push_exp("t1_rd", c_t_ack, 1'b1, 32'hDEAD_BEEF, 1);
        run_xfer(0, 32'h10, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t1_rd");

        // Byte lanes
        wq.push_back(32'h1122_3344);
        push_exp("t2_wr0", c_t_ack, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h20, 1, 1'b1, 4'hF, 2'b00, 3'b000, -1, 0, "t2_wr0");
        wq.push_back(32'hAAAA_AAAA);
        push_exp("t2_wr1", c_t_ack, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h20, 1, 1'b1, 4'b0101, 2'b00, 3'b000, -1, 0, "t2_wr1");
        push_exp("t2_rd", c_t_ack, 1'b1, 32'h11AA_33AA, 1);
        run_xfer(0, 32'h20, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t2_rd");

        // Preload 0x30..0x3C with a linear write burst, then a wrap-4 read
        for (int i = 0; i < 4; i++) begin
            wq.push_back(32'(i));
            push_exp($sformatf("t3_pre%0d", i), c_t_ack, 1'b0, 32'h0, 1);
        end
        run_xfer(0, 32'h30, 4, 1'b1, 4'hF, 2'b00, 3'b010, -1, 0, "t3_pre");
        begin
            logic [31:0] a;
            a = 32'h38;
            for (int i = 0; i < 4; i++) begin
                push_exp($sformatf("t3_wrap%0d", i), c_t_ack, 1'b1, (a - 32'h30) >> 2, 1);
                a = next_adr(a, 2'b01);
            end
        end
        run_xfer(0, 32'h38, 4, 1'b0, 4'hF, 2'b01, 3'b010, -1, 0, "t3_wrap");

        // Wait states with a master stall after the second beat
        for (int i = 0; i < 4; i++) begin
            wq.push_back(32'hA000_0000 + 32'(i));
            push_exp($sformatf("t4_wr%0d", i), c_t_ack, 1'b0, 32'h0, 3);
        end
        run_xfer(1, 32'h0, 4, 1'b1, 4'hF, 2'b00, 3'b010, 1, 5, "t4_wr");
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("t4_rd%0d", i), c_t_ack, 1'b1, 32'hA000_0000 + 32'(i), 3);
            run_xfer(1, 32'(4 * i), 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t4_rd");
        end

        // Error and retry paths
        push_exp("t5_oor", c_t_err, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h400, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t5_oor");
        push_exp("t5_mis", c_t_err, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h2, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t5_mis");
        push_exp("t5_rty", c_t_rty, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h10, 1, 1'b0, 4'hF, 2'b00, 3'b001, -1, 0, "t5_rty");
        wq.push_back(32'h5555_0000);
        push_exp("t5_w0", c_t_ack, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h0, 1, 1'b1, 4'hF, 2'b00, 3'b000, -1, 0, "t5_w0");
        wq.push_back(32'h1111_1111);
        wq.push_back(32'h2222_2222);
        wq.push_back(32'hBAD0_BAD0);
        push_exp("t5_end0", c_t_ack, 1'b0, 32'h0, 1);
        push_exp("t5_end1", c_t_ack, 1'b0, 32'h0, 1);
        push_exp("t5_end2", c_t_err, 1'b0, 32'h0, 1);
        run_xfer(0, 32'h3F8, 3, 1'b1, 4'hF, 2'b00, 3'b010, -1, 0, "t5_end");
        push_exp("t5_rb0", c_t_ack, 1'b1, 32'h1111_1111, 1);
        run_xfer(0, 32'h3F8, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t5_rb0");
        push_exp("t5_rb1", c_t_ack, 1'b1, 32'h2222_2222, 1);
        run_xfer(0, 32'h3FC, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t5_rb1");
        push_exp("t5_rbw0", c_t_ack, 1'b1, 32'h5555_0000, 1);
        run_xfer(0, 32'h0, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t5_rbw0");

        // Asynchronous reset during the second beat of a read burst
        begin
            int lat;
            bit tmo;
            dsel = 0;
            adr = 32'h30; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
            cyc = 1'b1; stb = 1'b1;
            push_exp("t6_b0", c_t_ack, 1'b1, 32'd0, 1);
            wait_term(0, lat, tmo);
            score_beat(lat, tmo);
            @(posedge clk); #1;
            adr = 32'h34;
            push_exp("t6_b1", c_t_ack, 1'b1, 32'd1, 1);
            wait_term(1, lat, tmo);
            score_beat(lat, tmo);
            #1;
            rst_n = 1'b0;
            #1;
            check_val("t6_rst_ack", 32'(ack0), 32'd0);
            check_val("t6_rst_dat", rdat0, 32'd0);
            cyc = 1'b0; stb = 1'b0; cti = 3'b000;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end
        push_exp("t6_rd", c_t_ack, 1'b1, 32'hDEAD_BEEF, 1);
        run_xfer(0, 32'h10, 1, 1'b0, 4'hF, 2'b00, 3'b000, -1, 0, "t6_rd");

        if (sb.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_leftover: got %0d unconsumed entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
